// File: rtl/eth_pkg.sv
// Shared state encoding, header layout and byte-order helper
// for the Ethernet receive frame parser.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        FLUSH,
        DONE
    } eth_state_e;

    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    localparam logic [2:0] HDR_DST0 = 3'd0;
    localparam logic [2:0] HDR_DST1 = 3'd1;
    localparam logic [2:0] HDR_DST2 = 3'd2;
    localparam logic [2:0] HDR_SRC0 = 3'd3;
    localparam logic [2:0] HDR_SRC1 = 3'd4;
    localparam logic [2:0] HDR_SRC2 = 3'd5;
    localparam logic [2:0] HDR_TYPE = 3'd6;

    // Wire order puts [7:0] first; network order puts it in the high byte.
    function automatic logic [15:0] to_net16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/eth_rx_hold_stage.sv
// One-word payload hold register: emits each word once its successor
// arrives and frames the stream with SOP/EOP/err.
module eth_rx_hold_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [15:0] push_data_i,
    input  logic        flush_i,
    input  logic        abort_i,
    input  logic        ovf_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic        err_o
);

    logic        hold_vld_q, hold_vld_d;
    logic [15:0] hold_data_q, hold_data_d;
    logic        sop_done_q, sop_done_d;
    logic        pend_q, pend_d;
    logic        pend_err_q, pend_err_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        err_q, err_d;

    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        sop_done_d  = sop_done_q;
        pend_d      = 1'b0;
        pend_err_d  = 1'b0;
        data_d      = '0;
        valid_d     = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        err_d       = 1'b0;

        if (pend_q) begin
            // Last word arrived together with complete: close it out now.
            valid_d    = 1'b1;
            data_d     = hold_data_q;
            sop_d      = !sop_done_q;
            eop_d      = 1'b1;
            err_d      = pend_err_q;
            hold_vld_d = 1'b0;
            sop_done_d = 1'b0;
        end else if (abort_i) begin
            if (sop_done_q) begin
                valid_d = 1'b1;
                data_d  = hold_vld_q ? hold_data_q : 16'h0000;
                eop_d   = 1'b1;
                err_d   = 1'b1;
            end
            hold_vld_d = 1'b0;
            sop_done_d = 1'b0;
        end else begin
            if (push_i && hold_vld_q) begin
                valid_d    = 1'b1;
                data_d     = hold_data_q;
                sop_d      = !sop_done_q;
                sop_done_d = 1'b1;
            end
            if (push_i) begin
                hold_vld_d  = 1'b1;
                hold_data_d = push_data_i;
            end
            if (flush_i) begin
                if (push_i) begin
                    pend_d     = 1'b1;
                    pend_err_d = ovf_i;
                end else if (hold_vld_q) begin
                    valid_d    = 1'b1;
                    data_d     = hold_data_q;
                    sop_d      = !sop_done_q;
                    eop_d      = 1'b1;
                    err_d      = ovf_i;
                    hold_vld_d = 1'b0;
                    sop_done_d = 1'b0;
                end else begin
                    sop_done_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            sop_done_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_err_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            sop_done_q  <= sop_done_d;
            pend_q      <= pend_d;
            pend_err_q  <= pend_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign err_o   = err_q;

endmodule

// File: rtl/eth_rx_frame_parser.sv
// Ethernet receive frame parser: requests frames, parses the header,
// filters on destination MAC and forwards payload words.
module eth_rx_frame_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC         = 48'h0001_0203_0405,
    parameter int          MAX_PAYLOAD_WORDS = 750,
    parameter int          TIMEOUT_CYCLES    = 65535
) (
    input  logic        Clock,
    input  logic        Reset_N,
    input  logic        ethernet_int_in,
    output logic        ethernet_rcv_req_out,
    input  logic [15:0] ethernet_rcv_data_in,
    input  logic        ethernet_rcv_data_rdy_in,
    input  logic        ethernet_rcv_complete_in,
    output logic [15:0] payload_data_out,
    output logic        payload_valid_out,
    output logic        payload_sop_out,
    output logic        payload_eop_out,
    output logic        payload_err_out,
    output logic [15:0] ethertype_out,
    output logic [47:0] src_mac_out,
    output logic        frame_accepted_out,
    output logic        frame_dropped_out,
    output logic [15:0] accept_count_out,
    output logic [15:0] drop_count_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(MAX_PAYLOAD_WORDS + 1);

    eth_state_e    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   dst_q, dst_d;
    logic [47:0]   src_q, src_d;
    logic [47:0]   src_out_q, src_out_d;
    logic [15:0]   type_q, type_d;
    logic          rcv_req_q, rcv_req_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] pay_cnt_q, pay_cnt_d;
    logic          ovf_q, ovf_d;
    logic          acc_q, acc_d;
    logic          drop_q, drop_d;
    logic [15:0]   acc_cnt_q, acc_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic        push, flush, abort, ovf_now;
    logic        finish, accept, dst_match, timeout_hit;
    logic [15:0] word_net;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dst_d      = dst_q;
        src_d      = src_q;
        src_out_d  = src_out_q;
        type_d     = type_q;
        rcv_req_d  = rcv_req_q;
        tmo_d      = tmo_q;
        pay_cnt_d  = pay_cnt_q;
        ovf_d      = ovf_q;
        acc_d      = 1'b0;
        drop_d     = 1'b0;
        acc_cnt_d  = acc_cnt_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        flush      = 1'b0;
        abort      = 1'b0;
        ovf_now    = ovf_q;
        finish     = 1'b0;
        accept     = 1'b0;

        word_net    = to_net16(ethernet_rcv_data_in);
        dst_match   = ({dst_q, word_net} == LOCAL_MAC) ||
                      ({dst_q, word_net} == BROADCAST_MAC);
        timeout_hit = rcv_req_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

        if (rcv_req_q) begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ethernet_int_in) begin
                    state_d   = HDR;
                    rcv_req_d = 1'b1;
                    idx_d     = '0;
                    tmo_d     = '0;
                    pay_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            HDR: begin
                if (ethernet_rcv_data_rdy_in) begin
                    idx_d = idx_q + 3'd1;
                    unique case (idx_q)
                        HDR_DST0: dst_d[31:16] = word_net;
                        HDR_DST1: dst_d[15:0]  = word_net;
                        HDR_DST2: if (!dst_match) state_d = FLUSH;
                        HDR_SRC0: src_d[47:32] = word_net;
                        HDR_SRC1: src_d[31:16] = word_net;
                        HDR_SRC2: src_d[15:0]  = word_net;
                        HDR_TYPE: begin
                            state_d   = PAY;
                            src_out_d = src_q;
                            type_d    = word_net;
                        end
                        default: ;
                    endcase
                end
                // A header finishing on this very word is a zero-payload frame.
                if (ethernet_rcv_complete_in) begin
                    finish = 1'b1;
                    accept = ethernet_rcv_data_rdy_in && (idx_q == HDR_TYPE);
                end
            end
            PAY: begin
                if (ethernet_rcv_data_rdy_in) begin
                    if (pay_cnt_q < PW'(MAX_PAYLOAD_WORDS)) begin
                        push      = 1'b1;
                        pay_cnt_d = pay_cnt_q + 1'b1;
                    end else begin
                        ovf_d   = 1'b1;
                        ovf_now = 1'b1;
                    end
                end
                if (ethernet_rcv_complete_in) begin
                    finish = 1'b1;
                    accept = 1'b1;
                    flush  = 1'b1;
                end
            end
            FLUSH: begin
                if (ethernet_rcv_complete_in) begin
                    finish = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout_hit && !finish) begin
            finish = 1'b1;
            accept = 1'b0;
            abort  = (state_q == PAY);
            push   = 1'b0;
        end

        if (finish) begin
            state_d   = DONE;
            rcv_req_d = 1'b0;
            if (accept) begin
                acc_d     = 1'b1;
                acc_cnt_d = acc_cnt_q + 16'd1;
            end else begin
                drop_d     = 1'b1;
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            src_out_q  <= '0;
            type_q     <= '0;
            rcv_req_q  <= 1'b0;
            tmo_q      <= '0;
            pay_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            acc_q      <= 1'b0;
            drop_q     <= 1'b0;
            acc_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            src_out_q  <= src_out_d;
            type_q     <= type_d;
            rcv_req_q  <= rcv_req_d;
            tmo_q      <= tmo_d;
            pay_cnt_q  <= pay_cnt_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
            drop_q     <= drop_d;
            acc_cnt_q  <= acc_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    eth_rx_hold_stage u_hold (
        .clk         (Clock),
        .rst_n       (Reset_N),
        .push_i      (push),
        .push_data_i (ethernet_rcv_data_in),
        .flush_i     (flush),
        .abort_i     (abort),
        .ovf_i       (ovf_now),
        .data_o      (payload_data_out),
        .valid_o     (payload_valid_out),
        .sop_o       (payload_sop_out),
        .eop_o       (payload_eop_out),
        .err_o       (payload_err_out)
    );

    assign ethernet_rcv_req_out = rcv_req_q;
    assign ethertype_out        = type_q;
    assign src_mac_out          = src_out_q;
    assign frame_accepted_out   = acc_q;
    assign frame_dropped_out    = drop_q;
    assign accept_count_out     = acc_cnt_q;
    assign drop_count_out       = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser with a frame-level expected
// beat/result model and a per-cycle compare process.
module tb_eth_rx_frame_parser;

    localparam logic [47:0] LMAC = 48'h0001_0203_0405;
    localparam int          MAXW = 4;
    localparam int          TMO  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_in = 1'b0;
    logic        rdy = 1'b0;
    logic        cmpl = 1'b0;
    logic [15:0] din = '0;

    logic        rcv_req;
    logic [15:0] p_data;
    logic        p_valid, p_sop, p_eop, p_err;
    logic [15:0] etype;
    logic [47:0] smac;
    logic        f_acc, f_drop;
    logic [15:0] acc_cnt, drop_cnt;

    eth_rx_frame_parser #(
        .LOCAL_MAC         (LMAC),
        .MAX_PAYLOAD_WORDS (MAXW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .Clock                    (clk),
        .Reset_N                  (rst_n),
        .ethernet_int_in          (int_in),
        .ethernet_rcv_req_out     (rcv_req),
        .ethernet_rcv_data_in     (din),
        .ethernet_rcv_data_rdy_in (rdy),
        .ethernet_rcv_complete_in (cmpl),
        .payload_data_out         (p_data),
        .payload_valid_out        (p_valid),
        .payload_sop_out          (p_sop),
        .payload_eop_out          (p_eop),
        .payload_err_out          (p_err),
        .ethertype_out            (etype),
        .src_mac_out              (smac),
        .frame_accepted_out       (f_acc),
        .frame_dropped_out        (f_drop),
        .accept_count_out         (acc_cnt),
        .drop_count_out           (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        err;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    t_rise, t_fall;
    int    model_acc, model_drop;
    beat_t exp_q[$];
    bit    exp_res[$];
    beat_t last_beat;
    logic  pre_req, post_v, post_sop, post_eop, post_err, post_req;
    logic [15:0] post_d;
    logic [15:0] f[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_eq(input string nm, input logic [63:0] act,
                          input logic [63:0] exp);
        chk(act == exp, nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level expectation from the filtering/truncation/timeout rules.
    task automatic model_frame(input logic [15:0] w[$], input bit done);
        logic [47:0] dst;
        int np, n;
        beat_t b;
        if (w.size() < 7) begin
            exp_res.push_back(1'b0);
            return;
        end
        for (int k = 0; k < 3; k++) begin
            dst[47 - 16*k -: 8] = w[k][7:0];
            dst[39 - 16*k -: 8] = w[k][15:8];
        end
        if (dst != LMAC && dst != 48'hFFFF_FFFF_FFFF) begin
            exp_res.push_back(1'b0);
            return;
        end
        np = w.size() - 7;
        n  = (np > MAXW) ? MAXW : np;
        exp_res.push_back(done);
        if (!done && n < 2) return;
        for (int i = 0; i < n; i++) begin
            b.d   = w[7 + i];
            b.sop = (i == 0);
            b.eop = (i == n - 1);
            b.err = (i == n - 1) && (done ? (np > MAXW) : 1'b1);
            exp_q.push_back(b);
        end
    endtask

    task automatic monitor();
        beat_t b, e;
        bit r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_res.delete();
                model_acc  = 0;
                model_drop = 0;
                continue;
            end
            if (p_valid) begin
                b = '{p_data, p_sop, p_eop, p_err};
                last_beat = b;
                chk(exp_q.size() > 0, "beat_expected",
                    64'(b), 64'(0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_eq("beat", 64'(b), 64'(e));
                end
            end
            if (f_acc || f_drop) begin
                chk(exp_res.size() > 0, "result_expected",
                    64'({f_acc, f_drop}), 64'(0));
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    chk_eq("accepted", 64'(f_acc), 64'(r));
                    chk_eq("dropped", 64'(f_drop), 64'(!r));
                    if (r) model_acc++;
                    else model_drop++;
                    chk_eq("accept_count", 64'(acc_cnt),
                           64'(16'(model_acc)));
                    chk_eq("drop_count", 64'(drop_cnt),
                           64'(16'(model_drop)));
                end
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] w[$], input bit done);
        int n;
        int_in = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rcv_req && n < 20);
        chk_eq("rcv_req_rise", 64'(rcv_req), 64'(1));
        t_rise = cyc;
        int_in = 1'b0;
        foreach (w[i]) begin
            din = w[i];
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
            din = '0;
            tick();
        end
        if (done) begin
            cmpl = 1'b1;
            @(negedge clk);
            pre_req = rcv_req;
            @(negedge clk);
            post_v   = p_valid;
            post_sop = p_sop;
            post_eop = p_eop;
            post_err = p_err;
            post_d   = p_data;
            post_req = rcv_req;
            cmpl = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk_eq({tag, "_req"}, 64'(rcv_req), 64'(0));
        chk_eq({tag, "_valid"}, 64'({p_valid, p_sop, p_eop, p_err}), 64'(0));
        chk_eq({tag, "_data"}, 64'(p_data), 64'(0));
        chk_eq({tag, "_pulses"}, 64'({f_acc, f_drop}), 64'(0));
        chk_eq({tag, "_acc_cnt"}, 64'(acc_cnt), 64'(0));
        chk_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(0));
        chk_eq({tag, "_etype"}, 64'(etype), 64'(0));
        chk_eq({tag, "_smac"}, 64'(smac), 64'(0));
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        rst_n = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Unicast match, three payload words.
        f = '{16'h0100, 16'h0302, 16'h0504, 16'h0B0A, 16'h0D0C, 16'h0F0E,
              16'h0008, 16'h1111, 16'h2222, 16'h3333};
        model_frame(f, 1'b1);
        send_frame(f, 1'b1);
        chk_eq("f1_eop_beat", 64'({post_v, post_eop, post_d}),
               64'({1'b1, 1'b1, 16'h3333}));
        chk_eq("f1_etype", 64'(etype), 64'(16'h0800));
        chk_eq("f1_smac", 64'(smac), 64'(48'h0A0B_0C0D_0E0F));
        chk_eq("f1_acc_cnt", 64'(acc_cnt), 64'(1));
        chk_eq("f1_drained", 64'(exp_q.size() + exp_res.size()), 64'(0));

        // Broadcast, single payload word.
        f = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2211, 16'h4433, 16'h6655,
              16'hDD86, 16'hABCD};
        model_frame(f, 1'b1);
        send_frame(f, 1'b1);
        chk_eq("f2_beat", 64'({post_v, post_sop, post_eop, post_err, post_d}),
               64'({4'b1110, 16'hABCD}));
        chk_eq("f2_etype", 64'(etype), 64'(16'h86DD));
        chk_eq("f2_acc_cnt", 64'(acc_cnt), 64'(2));

        // Destination mismatch in the last address byte.
        f = '{16'h0100, 16'h0302, 16'h0604, 16'h0B0A, 16'h0D0C, 16'h0F0E,
              16'h0008, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        model_frame(f, 1'b1);
        send_frame(f, 1'b1);
        chk_eq("f3_req_before", 64'(pre_req), 64'(1));
        chk_eq("f3_req_after", 64'(post_req), 64'(0));
        chk_eq("f3_drop_cnt", 64'(drop_cnt), 64'(1));
        chk_eq("f3_etype_kept", 64'(etype), 64'(16'h86DD));

        // Runt: complete after word 4.
        f = '{16'h0100, 16'h0302, 16'h0504, 16'h0B0A, 16'h0D0C};
        model_frame(f, 1'b1);
        send_frame(f, 1'b1);
        chk_eq("f4_drop_cnt", 64'(drop_cnt), 64'(2));
        chk_eq("f4_idle_req", 64'(rcv_req), 64'(0));

        // Oversize: six payload words against a limit of four.
        f = '{16'h0100, 16'h0302, 16'h0504, 16'h0B0A, 16'h0D0C, 16'h0F0E,
              16'h0008, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005,
              16'hA006};
        model_frame(f, 1'b1);
        send_frame(f, 1'b1);
        chk_eq("f5_last", 64'({post_v, post_eop, post_err, post_d}),
               64'({3'b111, 16'hA004}));
        chk_eq("f5_acc_cnt", 64'(acc_cnt), 64'(3));
        chk_eq("f5_drained", 64'(exp_q.size() + exp_res.size()), 64'(0));

        // Timeout with two payload words and no complete.
        f = '{16'h0100, 16'h0302, 16'h0504, 16'h0B0A, 16'h0D0C, 16'h0F0E,
              16'h0008, 16'h5555, 16'h6666};
        model_frame(f, 1'b0);
        send_frame(f, 1'b0);
        n = 0;
        while (rcv_req && n < 3 * TMO) begin
            tick();
            n++;
        end
        t_fall = cyc;
        chk_eq("f6_req_cycles", 64'(t_fall - t_rise), 64'(TMO));
        repeat (3) tick();
        chk_eq("f6_last", 64'(last_beat), 64'({16'h6666, 3'b011}));
        chk_eq("f6_drop_cnt", 64'(drop_cnt), 64'(3));
        chk_eq("f6_drained", 64'(exp_q.size() + exp_res.size()), 64'(0));

        // Reset in the middle of the payload.
        f = '{16'h0100, 16'h0302, 16'h0504, 16'h0B0A, 16'h0D0C, 16'h0F0E,
              16'h0008, 16'h7777, 16'h8888};
        exp_q.push_back('{16'h7777, 1'b1, 1'b0, 1'b0});
        send_frame(f, 1'b0);
        chk_eq("f7_req_in_pay", 64'(rcv_req), 64'(1));
        chk_eq("f7_drained_pre", 64'(exp_q.size()), 64'(0));
        rst_n = 1'b0;
        tick();
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Counting restarts from zero after the reset.
        f = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2211, 16'h4433, 16'h6655,
              16'h0008, 16'h0F0F};
        model_frame(f, 1'b1);
        send_frame(f, 1'b1);
        chk_eq("f8_beat", 64'({post_v, post_sop, post_eop, post_err, post_d}),
               64'({4'b1110, 16'h0F0F}));
        chk_eq("f8_acc_cnt", 64'(acc_cnt), 64'(1));
        chk_eq("f8_drained", 64'(exp_q.size() + exp_res.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_parser.md
Name: eth_rx_frame_parser

Overview:
- Sits directly downstream of the Ethernet controller's receive interface: the rcv_req/rcv_data/rcv_data_rdy/rcv_complete/int port group.
- On a receive interrupt it requests a frame and consumes the 16-bit word stream. It parses destination MAC, source MAC and EtherType.
- Frames are filtered against the local MAC and broadcast. Accepted payload goes out as a framed word stream with SOP/EOP; per-frame accept/drop statistics are kept.

Parameters:
- LOCAL_MAC, 48'h0001_0203_0405, station address; bits [47:40] are the first byte on the wire.
- MAX_PAYLOAD_WORDS, 750, payload words forwarded per frame; excess words are discarded and the frame is flagged.
- TIMEOUT_CYCLES, 65535, cycles allowed from request to rcv_complete before abort.

Ports:
- Clock  in  1  system clock (25 MHz domain)
- Reset_N  in  1  synchronous, active-low reset
- ethernet_int_in  in  1  level: controller holds a received frame
- ethernet_rcv_req_out  out  1  frame request, held high until complete or abort
- ethernet_rcv_data_in  in  16  received word; [7:0] is the earlier byte on the wire
- ethernet_rcv_data_rdy_in  in  1  one-cycle strobe, one word per strobe
- ethernet_rcv_complete_in  in  1  one-cycle strobe, frame finished
- payload_data_out  out  16  payload word, wire byte order preserved
- payload_valid_out  out  1  payload word valid
- payload_sop_out  out  1  first payload word of frame
- payload_eop_out  out  1  last payload word of frame
- payload_err_out  out  1  valid with EOP: frame was truncated (oversize)
- ethertype_out  out  16  network order ({byte12,byte13}); stable from first payload word to next frame
- src_mac_out  out  48  sender MAC, same stability as ethertype_out
- frame_accepted_out  out  1  one-cycle pulse per accepted frame
- frame_dropped_out  out  1  one-cycle pulse per dropped frame
- accept_count_out  out  16  accepted-frame count, wraps 0xFFFF->0
- drop_count_out  out  16  dropped-frame count, wraps

Behaviour:
- Reset (Reset_N low at a Clock edge): state IDLE; all outputs 0; counters 0; word index 0; timeout counter 0; hold register empty.
- Reset mid-frame aborts immediately. No EOP or pulse is emitted, and rcv_req drops on the next cycle.
- States and transitions:
  - IDLE: if ethernet_int_in is high, go to HDR and assert rcv_req on the following cycle.
  - HDR: words 0-2 are destination MAC; words 3-5 are source MAC; word 6 is EtherType.
    - Destination match means equal to LOCAL_MAC or 48'hFFFF_FFFF_FFFF.
    - Mismatch is decided at word 2: go to FLUSH.
    - Match after word 6: go to PAY.
  - PAY: forwards payload words.
  - FLUSH: swallows words until complete.
  - DONE: lasts one cycle. Deassert rcv_req, pulse accepted or dropped, update the counter, return to IDLE.
- Payload latency: one-word hold register. Word N is output, with valid, on the cycle after word N+1's rdy strobe.
  - rcv_complete flushes the held word with EOP on the following cycle.
  - SOP is on the first emitted word. A single-word payload has SOP and EOP together.
- Accepted frame with zero payload words: no payload beats. frame_accepted still pulses.
- rdy and complete in the same cycle: the word is consumed first, then complete is processed.
- Runt: complete arrives before word 6 of a matching frame. Go to DONE, dropped, with no payload output.
- Oversize: words beyond MAX_PAYLOAD_WORDS are discarded. payload_err_out is set with EOP. Counted as accepted.
- Timeout: the counter runs while rcv_req is high. At TIMEOUT_CYCLES go to DONE with dropped.
  - If PAY had already emitted SOP, a final EOP beat is emitted with err=1. It carries the held word, or 0 if the hold register is empty.
- rdy strobes are ignored while in IDLE or DONE. ethernet_int_in is ignored outside IDLE.
- Byte assembly: the MAC byte at even offset 2k is word k [7:0]; odd offset 2k+1 is word k [15:8].
- There is no backpressure on the payload stream. The consumer must accept one word per cycle.

Decomposition:
- Shared package eth_pkg:
  - state enum (IDLE, HDR, PAY, FLUSH, DONE);
  - BROADCAST_MAC constant;
  - header word offsets (DST 0-2, SRC 3-5, TYPE 6);
  - function swapping a 16-bit word to network order.
- One natural sub-module: eth_rx_hold_stage, the one-word hold register that generates valid/SOP/EOP/err.

Test Plan:
- Matching frame, dst 00:01:02:03:04:05, type 0x0800, payload words 0x1111, 0x2222, 0x3333, then complete → 3 valid beats; SOP on 0x1111; EOP on 0x3333 the cycle after complete; ethertype_out=0x0800; accept_count=1.
- Broadcast dst FF:FF:FF:FF:FF:FF, 1 payload word 0xABCD → single beat with SOP=EOP=1, err=0; accepted pulse.
- Dst 00:01:02:03:04:06 with 5 payload words → no payload_valid; frame_dropped pulse; drop_count=1; rcv_req low one cycle after complete.
- Runt: matching dst, complete after word 4 → no payload; drop_count increments; state returns to IDLE.
- MAX_PAYLOAD_WORDS=4 with 6 payload words → 4 beats, the last with EOP and err=1; accept_count increments.
- TIMEOUT_CYCLES=100, match plus 2 payload words, then no complete → at cycle 100 EOP with err=1; dropped pulse. Also: Reset_N low mid-PAY → all outputs 0 next cycle, counters 0.
